// File: rtl/dmac_pkg.sv
// Shared encodings for the DMAC configuration slave: AHB-Lite transfer/response
// codes, register offsets and slave FSM states.
package dmac_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [7:0] OFS_SADDR = 8'h00;
    localparam logic [7:0] OFS_DADDR = 8'h04;
    localparam logic [7:0] OFS_TSIZE = 8'h08;
    localparam logic [7:0] OFS_CTRL  = 8'h0C;
    localparam logic [7:0] OFS_ARM   = 8'h20;

    // Kept as plain constants so older tools and netlist dumps see raw codes.
    typedef logic [1:0] slv_state_t;
    localparam slv_state_t S_IDLE = 2'd0;
    localparam slv_state_t S_WAIT = 2'd1;
    localparam slv_state_t S_ERR1 = 2'd2;
    localparam slv_state_t S_ERR2 = 2'd3;

endpackage

// File: rtl/dmac_cfg_regfile.sv
// Two descriptors of four words each. Flags address-phase hits and writes that
// target a descriptor whose DMA request is still pending.
module dmac_cfg_regfile
    import dmac_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-3:0] chk_waddr,
    input  logic [1:0]        dmac_req,
    output logic              desc_hit,
    output logic              desc_locked,
    input  logic              wr_en,
    input  logic [ADDR_W-3:0] acc_waddr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [1:0][3:0][DATA_W-1:0] desc_q, desc_d;
    logic                        acc_hit;

    // Word addresses 0..7 cover both descriptors; bit 2 selects the descriptor.
    assign desc_hit    = (chk_waddr[ADDR_W-3:3] == '0);
    assign desc_locked = dmac_req[chk_waddr[2]];
    assign acc_hit     = (acc_waddr[ADDR_W-3:3] == '0);
    assign rd_data     = desc_q[acc_waddr[2]][acc_waddr[1:0]];

    always_comb begin
        desc_d = desc_q;
        if (wr_en && acc_hit)
            desc_d[acc_waddr[2]][acc_waddr[1:0]] = wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) desc_q <= '0;
        else     desc_q <= desc_d;
    end

endmodule

// File: rtl/dmac_cfg_slave.sv
// AHB-Lite configuration slave for the DMAC: descriptor storage, ARM register
// driving DmacReq, and a response FSM with a fixed number of wait states.
module dmac_cfg_slave
    import dmac_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              HSel,
    input  logic [ADDR_W-1:0] HAddr,
    input  logic [1:0]        HTrans,
    input  logic              HWrite,
    input  logic [2:0]        HSize,
    input  logic [DATA_W-1:0] HWData,
    input  logic              HReady,
    output logic              HReadyOut,
    output logic [1:0]        HResp,
    output logic [DATA_W-1:0] HRData,
    input  logic [1:0]        ReqAck,
    output logic [1:0]        DmacReq
);

    slv_state_t        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic              dphase_q, dphase_d;
    logic [1:0]        dmac_req_q, dmac_req_d;
    logic [DATA_W-1:0] hrdata_q, hrdata_d;

    logic              hready_out, accept, acc_err, complete;
    logic              chk_arm, acc_arm, desc_hit, desc_locked;
    logic [DATA_W-1:0] rf_rd_data, rd_word;

    assign hready_out = (state_q == S_IDLE) || (state_q == S_ERR2) ||
                        ((state_q == S_WAIT) && (cnt_q == '0));
    assign complete   = dphase_q && hready_out;

    assign accept  = HSel && HReady && hready_out &&
                     ((HTrans == TR_NONSEQ) || (HTrans == TR_SEQ));
    assign chk_arm = (HAddr == ADDR_W'(OFS_ARM));
    assign acc_arm = (addr_q == ADDR_W'(OFS_ARM));
    assign acc_err = !(desc_hit || chk_arm) || (HAddr[1:0] != 2'b00) ||
                     (HSize != HSIZE_WORD) || (HWrite && desc_hit && desc_locked);

    dmac_cfg_regfile #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .chk_waddr  (HAddr[ADDR_W-1:2]),
        .dmac_req   (dmac_req_q),
        .desc_hit   (desc_hit),
        .desc_locked(desc_locked),
        .wr_en      (complete && write_q),
        .acc_waddr  (addr_q[ADDR_W-1:2]),
        .wr_data    (HWData),
        .rd_data    (rf_rd_data)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        dphase_d = dphase_q;
        if (state_q == S_WAIT && cnt_q != '0) cnt_d = cnt_q - 2'd1;
        if (state_q == S_ERR1) state_d = S_ERR2;
        // Any ready cycle retires the current data phase and may take the next address phase.
        if (hready_out) begin
            state_d  = S_IDLE;
            dphase_d = 1'b0;
            if (accept) begin
                if (acc_err) begin
                    state_d = S_ERR1;
                end else begin
                    dphase_d = 1'b1;
                    addr_d   = HAddr;
                    write_d  = HWrite;
                    cnt_d    = 2'(WAIT_STATES);
                    state_d  = (WAIT_STATES == 0) ? S_IDLE : S_WAIT;
                end
            end
        end
    end

    // Arm is OR'ed after the ack mask so a same-cycle arm wins.
    always_comb begin
        dmac_req_d = dmac_req_q & ~ReqAck;
        if (complete && write_q && acc_arm) dmac_req_d = dmac_req_d | HWData[1:0];
    end

    always_comb begin
        rd_word  = acc_arm ? {{(DATA_W-2){1'b0}}, dmac_req_q} : rf_rd_data;
        hrdata_d = (complete && !write_q) ? rd_word : hrdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            dphase_q   <= 1'b0;
            dmac_req_q <= '0;
            hrdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            dphase_q   <= dphase_d;
            dmac_req_q <= dmac_req_d;
            hrdata_q   <= hrdata_d;
        end
    end

    assign HReadyOut = hready_out;
    assign HResp     = (state_q == S_ERR1 || state_q == S_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign HRData    = hrdata_d;
    assign DmacReq   = dmac_req_q;

endmodule

// File: tb/tb_dmac_cfg_slave.sv
// Directed bench: a transfer table on a one-wait-state slave plus hand-written
// sequences for ack/arm races, Busy, reset mid-transfer and zero-wait pipelining.
module tb_dmac_cfg_slave;
    import dmac_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        hsel = 0, hwrite = 0;
    logic [7:0]  haddr = 0;
    logic [1:0]  htrans = TR_IDLE, req_ack = 0;
    logic [2:0]  hsize = HSIZE_WORD;
    logic [31:0] hwdata = 0;
    logic        hready, hreadyout;
    logic [1:0]  hresp, dmac_req;
    logic [31:0] hrdata;

    logic        z_hsel = 0, z_hwrite = 0;
    logic [7:0]  z_haddr = 0;
    logic [1:0]  z_htrans = TR_IDLE, z_req_ack = 0;
    logic [2:0]  z_hsize = HSIZE_WORD;
    logic [31:0] z_hwdata = 0;
    logic        z_hready, z_hreadyout;
    logic [1:0]  z_hresp, z_dmac_req;
    logic [31:0] z_hrdata;

    assign hready   = hreadyout;
    assign z_hready = z_hreadyout;

    dmac_cfg_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst), .HSel(hsel), .HAddr(haddr), .HTrans(htrans),
        .HWrite(hwrite), .HSize(hsize), .HWData(hwdata), .HReady(hready),
        .HReadyOut(hreadyout), .HResp(hresp), .HRData(hrdata),
        .ReqAck(req_ack), .DmacReq(dmac_req)
    );

    dmac_cfg_slave #(.ADDR_W(8), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .HSel(z_hsel), .HAddr(z_haddr), .HTrans(z_htrans),
        .HWrite(z_hwrite), .HSize(z_hsize), .HWData(z_hwdata), .HReady(z_hready),
        .HReadyOut(z_hreadyout), .HResp(z_hresp), .HRData(z_hrdata),
        .ReqAck(z_req_ack), .DmacReq(z_dmac_req)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single Non_Seq transfer on the one-wait-state slave; bounded wait for ready.
    task automatic xfer(input logic wr, input logic [7:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic [1:0] resp_w, output logic [1:0] resp_f,
                        output int waits);
        hsel = 1; htrans = TR_NONSEQ; haddr = a; hwrite = wr; hsize = sz;
        @(posedge clk); #1;
        hsel = 0; htrans = TR_IDLE; hwdata = wd;
        waits = 0; rd = '0; resp_w = 2'b11; resp_f = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (hreadyout) begin
                resp_f = hresp; rd = hrdata;
                break;
            end
            waits++; resp_w = hresp;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [1:0]  req;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        logic [1:0]  rw, rf;
        int          w;

        vecs[0]  = '{1'b1, 8'h10, 3'b010, 32'h1000,     HRESP_OKAY,  32'h0,        2'b00};
        vecs[1]  = '{1'b1, 8'h14, 3'b010, 32'h2000,     HRESP_OKAY,  32'h0,        2'b00};
        vecs[2]  = '{1'b1, 8'h18, 3'b010, 32'h10,       HRESP_OKAY,  32'h0,        2'b00};
        vecs[3]  = '{1'b1, 8'h1C, 3'b010, 32'h3,        HRESP_OKAY,  32'h0,        2'b00};
        vecs[4]  = '{1'b1, 8'h00, 3'b010, 32'hA5A50001, HRESP_OKAY,  32'h0,        2'b00};
        vecs[5]  = '{1'b1, 8'h20, 3'b010, 32'h2,        HRESP_OKAY,  32'h0,        2'b10};
        vecs[6]  = '{1'b0, 8'h10, 3'b010, 32'h0,        HRESP_OKAY,  32'h1000,     2'b10};
        vecs[7]  = '{1'b0, 8'h14, 3'b010, 32'h0,        HRESP_OKAY,  32'h2000,     2'b10};
        vecs[8]  = '{1'b0, 8'h18, 3'b010, 32'h0,        HRESP_OKAY,  32'h10,       2'b10};
        vecs[9]  = '{1'b0, 8'h1C, 3'b010, 32'h0,        HRESP_OKAY,  32'h3,        2'b10};
        vecs[10] = '{1'b1, 8'h14, 3'b010, 32'hDEAD,     HRESP_ERROR, 32'h0,        2'b10};
        vecs[11] = '{1'b0, 8'h14, 3'b010, 32'h0,        HRESP_OKAY,  32'h2000,     2'b10};
        vecs[12] = '{1'b0, 8'h24, 3'b010, 32'h0,        HRESP_ERROR, 32'h0,        2'b10};
        vecs[13] = '{1'b0, 8'h02, 3'b010, 32'h0,        HRESP_ERROR, 32'h0,        2'b10};
        vecs[14] = '{1'b0, 8'h00, 3'b001, 32'h0,        HRESP_ERROR, 32'h0,        2'b10};
        vecs[15] = '{1'b0, 8'h00, 3'b010, 32'h0,        HRESP_OKAY,  32'hA5A50001, 2'b10};
        vecs[16] = '{1'b0, 8'h20, 3'b010, 32'h0,        HRESP_OKAY,  32'h2,        2'b10};

        // Reset state
        @(negedge clk);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp",     32'(hresp),     32'd0);
        chk("rst_hrdata",    hrdata,         32'd0);
        chk("rst_dmacreq",   32'(dmac_req),  32'd0);
        chk("rst_z_hready",  32'(z_hreadyout), 32'd1);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, rd, rw, rf, w);
            chk($sformatf("v%0d_waits", i),  32'(w),  32'd1);
            chk($sformatf("v%0d_resp_w", i), 32'(rw), 32'(vecs[i].resp));
            chk($sformatf("v%0d_resp_f", i), 32'(rf), 32'(vecs[i].resp));
            if (!vecs[i].wr && vecs[i].resp == HRESP_OKAY)
                chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_req", i), 32'(dmac_req), 32'(vecs[i].req));
        end

        // Ack clears an armed bit; ack of a clear bit does nothing
        req_ack = 2'b10; @(posedge clk); #1 req_ack = 2'b00;
        chk("ack_clear", 32'(dmac_req), 32'd0);
        req_ack = 2'b01; @(posedge clk); #1 req_ack = 2'b00;
        chk("ack_idle_bit", 32'(dmac_req), 32'd0);

        // Ack and arm of the same bit in the same cycle: arm wins
        hsel = 1; htrans = TR_NONSEQ; haddr = OFS_ARM; hwrite = 1; hsize = HSIZE_WORD;
        @(posedge clk); #1;
        hsel = 0; htrans = TR_IDLE; hwdata = 32'h2;
        @(posedge clk); #1 req_ack = 2'b10;
        @(negedge clk);
        chk("race_ready", 32'(hreadyout), 32'd1);
        @(posedge clk); #1 req_ack = 2'b00;
        chk("race_arm_wins", 32'(dmac_req), 32'd2);
        @(posedge clk); #1;
        chk("race_hold", 32'(dmac_req), 32'd2);

        // Busy with HSel=1 is a zero-wait OKAY with no effect
        hsel = 1; htrans = TR_BUSY; haddr = 8'h10; hwrite = 0;
        @(negedge clk);
        chk("busy_ready", 32'(hreadyout), 32'd1);
        chk("busy_resp",  32'(hresp),     32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_ready2", 32'(hreadyout), 32'd1);
        @(posedge clk); #1 hsel = 0; htrans = TR_IDLE;
        xfer(1'b0, 8'h10, HSIZE_WORD, 32'h0, rd, rw, rf, w);
        chk("busy_rd_waits", 32'(w), 32'd1);
        chk("busy_rd_data",  rd,     32'h1000);

        // Reset during the wait state of a TransSize write
        hsel = 1; htrans = TR_NONSEQ; haddr = OFS_TSIZE; hwrite = 1;
        @(posedge clk); #1;
        hsel = 0; htrans = TR_IDLE; hwdata = 32'h77;
        chk("pre_rst_wait", 32'(hreadyout), 32'd0);
        rst = 1; #1;
        chk("mid_rst_ready",  32'(hreadyout), 32'd1);
        chk("mid_rst_req",    32'(dmac_req),  32'd0);
        chk("mid_rst_hrdata", hrdata,         32'd0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        xfer(1'b0, OFS_TSIZE, HSIZE_WORD, 32'h0, rd, rw, rf, w);
        chk("post_rst_resp",  32'(rf), 32'd0);
        chk("post_rst_tsize", rd,      32'd0);
        xfer(1'b0, 8'h14, HSIZE_WORD, 32'h0, rd, rw, rf, w);
        chk("post_rst_daddr", rd, 32'd0);

        // Zero wait states: pipelined writes then back-to-back Seq reads
        z_hsel = 1; z_htrans = TR_NONSEQ; z_hwrite = 1; z_haddr = OFS_SADDR;
        @(posedge clk); #1;
        z_htrans = TR_SEQ; z_haddr = OFS_DADDR; z_hwdata = 32'h11;
        @(negedge clk);
        chk("z_w0_ready", 32'(z_hreadyout), 32'd1);
        @(posedge clk); #1;
        z_htrans = TR_NONSEQ; z_hwrite = 0; z_haddr = OFS_SADDR; z_hwdata = 32'h22;
        @(negedge clk);
        chk("z_w1_ready", 32'(z_hreadyout), 32'd1);
        @(posedge clk); #1;
        z_htrans = TR_SEQ; z_haddr = OFS_DADDR;
        @(negedge clk);
        chk("z_r0_ready", 32'(z_hreadyout), 32'd1);
        chk("z_r0_data",  z_hrdata,         32'h11);
        @(posedge clk); #1;
        z_htrans = TR_IDLE; z_hsel = 0;
        @(negedge clk);
        chk("z_r1_ready", 32'(z_hreadyout), 32'd1);
        chk("z_r1_data",  z_hrdata,         32'h22);
        chk("z_r1_resp",  32'(z_hresp),     32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("z_hold_data", z_hrdata, 32'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
